// File: rtl/bpb_assoc_if.sv
// Lookup/commit bus of the set-associative branch prediction buffer.
// slave = the BPB itself, master = the fetch/commit side driving it.
interface bpb_assoc_if #(
    parameter int LANES = 2
);
    logic                 stall;
    logic [LANES*32-1:0]  pc_predict;
    logic [LANES-1:0]     hit;
    logic [LANES-1:0]     taken;
    logic [LANES*32-1:0]  target;
    logic                 wen;
    logic [31:0]          pc_commit;
    logic                 commit_taken;
    logic [31:0]          commit_target;

    modport master (
        output stall, pc_predict, wen, pc_commit, commit_taken, commit_target,
        input  hit, taken, target
    );

    modport slave (
        input  stall, pc_predict, wen, pc_commit, commit_taken, commit_target,
        output hit, taken, target
    );
endinterface

// File: rtl/bpb_assoc.sv
// Set-associative branch prediction buffer: LANES lookups per cycle with
// registered (stall-held) results, one commit update per cycle with
// saturating direction counters and per-set round-robin replacement.
// Optional macro BPB_BYPASS_EN forwards a same-cycle commit into lookups.

// One lookup lane: tag compare across the ways of the selected set.
module bpb_lane #(
    parameter int WAYS  = 2,
    parameter int TAG_W = 10,
    parameter int CNT_W = 2
) (
    input  logic [TAG_W-1:0]             tag,
    input  logic [WAYS-1:0]              way_vld,
    input  logic [WAYS-1:0][TAG_W-1:0]   way_tag,
    input  logic [WAYS-1:0][CNT_W-1:0]   way_cnt,
    input  logic [WAYS-1:0][31:0]        way_tgt,
    output logic                         hit,
    output logic                         taken,
    output logic [31:0]                  tgt
);
    logic unused_cnt;
    assign unused_cnt = ^way_cnt;

    // Walk ways high to low so the lowest matching way wins.
    always_comb begin
        hit   = 1'b0;
        taken = 1'b0;
        tgt   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_vld[w] && (way_tag[w] == tag)) begin
                hit   = 1'b1;
                taken = way_cnt[w][CNT_W-1];
                tgt   = way_tgt[w];
            end
        end
    end
endmodule

module bpb_assoc #(
    parameter int SETS  = 64,
    parameter int WAYS  = 2,
    parameter int LANES = 2,
    parameter int TAG_W = 10,
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    bpb_assoc_if.slave  bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int VW    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);

    typedef logic [WAYS-1:0]             vld_row_t;
    typedef logic [WAYS-1:0][TAG_W-1:0]  tag_row_t;
    typedef logic [WAYS-1:0][CNT_W-1:0]  cnt_row_t;
    typedef logic [WAYS-1:0][31:0]       tgt_row_t;

    vld_row_t        vld_q [SETS];
    tag_row_t        tag_q [SETS];
    cnt_row_t        cnt_q [SETS];
    tgt_row_t        tgt_q [SETS];
    logic [VW-1:0]   vic_q [SETS];

    // Only the index/tag bits of the PCs matter.
    logic unused_pc;
    assign unused_pc = ^{bus.pc_predict, bus.pc_commit};

    logic [IDX_W-1:0] c_idx;
    logic [TAG_W-1:0] c_tag;
    assign c_idx = bus.pc_commit[IDX_W+1:2];
    assign c_tag = bus.pc_commit[IDX_W+TAG_W+1:IDX_W+2];

    vld_row_t      n_vld;
    tag_row_t      n_tag;
    cnt_row_t      n_cnt;
    tgt_row_t      n_tgt;
    logic [VW-1:0] n_vic;
    logic          c_upd;
    logic          hit_f, inv_f;
    logic [VW-1:0] hit_w, inv_w, al_w;

    // Commit: find hit / free way, then build the post-update set row.
    always_comb begin
        n_vld = vld_q[c_idx];
        n_tag = tag_q[c_idx];
        n_cnt = cnt_q[c_idx];
        n_tgt = tgt_q[c_idx];
        n_vic = vic_q[c_idx];
        c_upd = 1'b0;
        hit_f = 1'b0;
        inv_f = 1'b0;
        hit_w = '0;
        inv_w = '0;
        al_w  = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (n_vld[w] && (n_tag[w] == c_tag)) begin
                hit_f = 1'b1;
                hit_w = VW'(w);
            end
            if (!n_vld[w]) begin
                inv_f = 1'b1;
                inv_w = VW'(w);
            end
        end
        if (bus.wen) begin
            if (hit_f) begin
                c_upd = 1'b1;
                if (bus.commit_taken) begin
                    if (n_cnt[hit_w] != CNT_MAX) n_cnt[hit_w] = n_cnt[hit_w] + CNT_W'(1);
                    n_tgt[hit_w] = bus.commit_target;
                end else if (n_cnt[hit_w] != '0) begin
                    n_cnt[hit_w] = n_cnt[hit_w] - CNT_W'(1);
                end
            end else if (bus.commit_taken) begin
                c_upd = 1'b1;
                al_w  = inv_f ? inv_w : vic_q[c_idx];
                n_vld[al_w] = 1'b1;
                n_tag[al_w] = c_tag;
                n_cnt[al_w] = CNT_WT;
                n_tgt[al_w] = bus.commit_target;
                // Only an eviction moves the round-robin pointer.
                if (!inv_f) n_vic = VW'((32'(vic_q[c_idx]) + 1) % WAYS);
            end
        end
    end

    // Table state: cleared on reset, one set row rewritten per commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                vld_q[s] <= '0;
                tag_q[s] <= '0;
                cnt_q[s] <= '0;
                tgt_q[s] <= '0;
                vic_q[s] <= '0;
            end
        end else if (c_upd) begin
            vld_q[c_idx] <= n_vld;
            tag_q[c_idx] <= n_tag;
            cnt_q[c_idx] <= n_cnt;
            tgt_q[c_idx] <= n_tgt;
            vic_q[c_idx] <= n_vic;
        end
    end

    logic [LANES-1:0]        l_hit, l_taken;
    logic [LANES-1:0][31:0]  l_tgt;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [IDX_W-1:0] idx;
        logic [TAG_W-1:0] tag;
        logic             byp;
        assign idx = bus.pc_predict[32*l+2 +: IDX_W];
        assign tag = bus.pc_predict[32*l+IDX_W+2 +: TAG_W];
`ifdef BPB_BYPASS_EN
        // Same set being written this cycle: look at the post-update row.
        assign byp = c_upd && (idx == c_idx);
`else
        assign byp = 1'b0;
`endif
        bpb_lane #(.WAYS(WAYS), .TAG_W(TAG_W), .CNT_W(CNT_W)) u_lane (
            .tag     (tag),
            .way_vld (byp ? n_vld : vld_q[idx]),
            .way_tag (byp ? n_tag : tag_q[idx]),
            .way_cnt (byp ? n_cnt : cnt_q[idx]),
            .way_tgt (byp ? n_tgt : tgt_q[idx]),
            .hit     (l_hit[l]),
            .taken   (l_taken[l]),
            .tgt     (l_tgt[l])
        );
    end

    logic [LANES-1:0]        hit_q, taken_q;
    logic [LANES-1:0][31:0]  out_tgt_q;

    // Lookup result registers; held while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q     <= '0;
            taken_q   <= '0;
            out_tgt_q <= '0;
        end else if (!bus.stall) begin
            hit_q     <= l_hit;
            taken_q   <= l_taken;
            out_tgt_q <= l_tgt;
        end
    end

    assign bus.hit    = hit_q;
    assign bus.taken  = taken_q;
    assign bus.target = out_tgt_q;
endmodule

// File: tb/tb_bpb_assoc.sv
// Directed bench for bpb_assoc (default parameters: 64 sets, 2 ways, 2 lanes).
module tb_bpb_assoc;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bpb_assoc_if #(.LANES(2)) bif ();

    bpb_assoc #(.SETS(64), .WAYS(2), .LANES(2), .TAG_W(10), .CNT_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    // All in set 4 (pc[7:2]=4) with tags 0,1,2; D in set 9, E in set 12.
    localparam logic [31:0] PA = 32'h0040_0010;
    localparam logic [31:0] PB = 32'h0040_0110;
    localparam logic [31:0] PC = 32'h0040_0210;
    localparam logic [31:0] PD = 32'h0040_0024;
    localparam logic [31:0] PE = 32'h0040_0030;
    localparam logic [31:0] TA  = 32'h0040_0100;
    localparam logic [31:0] TA2 = 32'h0040_0700;
    localparam logic [31:0] TB  = 32'h0040_0500;
    localparam logic [31:0] TC  = 32'h0040_0600;
    localparam logic [31:0] TD  = 32'h0040_0900;

    int n_vec = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] h, input logic [1:0] t,
                           input logic [63:0] tg);
        chk({tag, ".hit"},    {62'd0, bif.hit},   {62'd0, h});
        chk({tag, ".taken"},  {62'd0, bif.taken}, {62'd0, t});
        chk({tag, ".target"}, bif.target,         tg);
    endtask

    task automatic commit(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        bif.wen = 1'b1;
        bif.pc_commit = pc;
        bif.commit_taken = tk;
        bif.commit_target = tgt;
    endtask

    initial begin
        reset = 1'b1;
        bif.stall = 1'b0;
        bif.pc_predict = '0;
        bif.wen = 1'b0;
        bif.pc_commit = '0;
        bif.commit_taken = 1'b0;
        bif.commit_target = '0;
        tick();
        tick();
        chk_out("reset", 2'b00, 2'b00, 64'd0);

        // Empty table lookup
        reset = 1'b0;
        bif.pc_predict = {PA, PA};
        tick();
        chk_out("empty", 2'b00, 2'b00, 64'd0);

        // Allocate A while looking it up in the same cycle
        commit(PA, 1'b1, TA);
        tick();
`ifdef BPB_BYPASS_EN
        chk_out("alloc_same_cyc", 2'b11, 2'b11, {TA, TA});
`else
        chk_out("alloc_same_cyc", 2'b00, 2'b00, 64'd0);
`endif
        bif.wen = 1'b0;
        tick();
        chk_out("alloc_a", 2'b11, 2'b11, {TA, TA});

        // Not-taken: 2 -> 1; target retained (commit_target ignored)
        commit(PA, 1'b0, 32'hDEAD_BEEC);
        tick();
        bif.wen = 1'b0;
        tick();
        chk_out("nt1", 2'b11, 2'b00, {TA, TA});

        // 1 -> 0 -> 0 (saturate low)
        commit(PA, 1'b0, 32'hDEAD_BEEC);
        tick();
        tick();
        bif.wen = 1'b0;
        tick();
        chk_out("nt_sat", 2'b11, 2'b00, {TA, TA});

        // 0 -> 1: still not taken (a wrap to 3 would show taken)
        commit(PA, 1'b1, TA);
        tick();
        bif.wen = 1'b0;
        tick();
        chk_out("t_from0", 2'b11, 2'b00, {TA, TA});

        // 1 -> 2: taken again
        commit(PA, 1'b1, TA);
        tick();
        bif.wen = 1'b0;
        tick();
        chk_out("t_from1", 2'b11, 2'b11, {TA, TA});

        // B fills way 1, C evicts way 0 (A)
        commit(PB, 1'b1, TB);
        tick();
        commit(PC, 1'b1, TC);
        tick();
        bif.wen = 1'b0;
        bif.pc_predict = {PB, PA};
        tick();
        chk_out("evict_a", 2'b10, 2'b10, {TB, 32'd0});
        bif.pc_predict = {PB, PC};
        tick();
        chk_out("b_c_hit", 2'b11, 2'b11, {TB, TC});

        // Stall 3 cycles with changing PCs and a commit of A (evicts B, way 1)
        bif.stall = 1'b1;
        bif.pc_predict = {PA, PA};
        commit(PA, 1'b1, TA2);
        tick();
        bif.wen = 1'b0;
        chk_out("stall1", 2'b11, 2'b11, {TB, TC});
        bif.pc_predict = {PD, PE};
        tick();
        chk_out("stall2", 2'b11, 2'b11, {TB, TC});
        tick();
        chk_out("stall3", 2'b11, 2'b11, {TB, TC});
        bif.stall = 1'b0;
        bif.pc_predict = {PB, PA};
        tick();
        chk_out("post_stall", 2'b01, 2'b01, {32'd0, TA2});

        // Same-cycle commit and lookup of new PC D in another set
        commit(PD, 1'b1, TD);
        bif.pc_predict = {PD, PD};
        tick();
`ifdef BPB_BYPASS_EN
        chk_out("byp_d", 2'b11, 2'b11, {TD, TD});
`else
        chk_out("byp_d", 2'b00, 2'b00, 64'd0);
`endif
        bif.wen = 1'b0;
        tick();
        chk_out("d_hit", 2'b11, 2'b11, {TD, TD});

        // Miss + not-taken commit leaves no entry
        commit(PE, 1'b0, 32'h1234_5678);
        tick();
        bif.wen = 1'b0;
        bif.pc_predict = {PE, PE};
        tick();
        chk_out("miss_nt", 2'b00, 2'b00, 64'd0);

        // Reset beats stall and wen
        bif.pc_predict = {PD, PD};
        tick();
        chk_out("pre_rst", 2'b11, 2'b11, {TD, TD});
        reset = 1'b1;
        bif.stall = 1'b1;
        commit(PE, 1'b1, 32'h1234_5678);
        tick();
        chk_out("rst_over_stall", 2'b00, 2'b00, 64'd0);
        reset = 1'b0;
        bif.stall = 1'b0;
        bif.wen = 1'b0;
        bif.pc_predict = {PE, PD};
        tick();
        chk_out("rst_cleared", 2'b00, 2'b00, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
